// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC -> IM request/ack -> buffered word to ID (valid/ready).
// Define FETCH_SKID_EN for a 2-entry output FIFO that allows one fetch per cycle.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam logic [31:0] RESET_PC_C = {RESET_PC[31:2], 2'b00};
  localparam logic [7:0]  TIMEOUT_C  = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        drop_q, drop_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        im_req_q, im_req_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        fetch_err_q, fetch_err_d;
`ifdef FETCH_SKID_EN
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_out_q, skid_out_d;
  logic [31:0] skid_pc_q, skid_pc_d;
`endif

  logic        load_s;
  logic        flush_s;
  logic        pop_s;
  logic        free_s;
  logic [31:0] redir_pc_s;
  logic [7:0]  cnt_inc_s;
  logic        unused_s;

  assign redir_pc_s = {redirect_pc[31:2], 2'b00};
  assign cnt_inc_s  = wait_cnt_q + 8'd1;
  assign pop_s      = inst_valid_q & id_ready;
  assign unused_s   = ^redirect_pc[1:0];

  assign im_req     = im_req_q;
  assign im_addr    = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_out_q;
  assign inst_pc    = inst_pc_q;
  assign fetch_err  = fetch_err_q;

  // Next-state, pc/redirect handling, output buffer update and request decode
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    drop_d       = drop_q;
    wait_cnt_d   = wait_cnt_q;
    fetch_err_d  = fetch_err_q;
    inst_valid_d = inst_valid_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
`ifdef FETCH_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_out_d   = skid_out_q;
    skid_pc_d    = skid_pc_q;
`endif
    load_s       = 1'b0;
    flush_s      = 1'b0;
    free_s       = 1'b0;

    // A redirect against an outstanding request parks the target until the stale ack returns
    case (state_q)
      IDLE, WAIT: begin
        if (redirect) begin
          pc_d    = redir_pc_s;
          flush_s = 1'b1;
        end else begin
          flush_s = 1'b0;
        end
      end
      REQ: begin
        if (im_ack) begin
          wait_cnt_d = 8'd0;
          drop_d     = 1'b0;
          if (redirect) begin
            pc_d    = redir_pc_s;
            flush_s = 1'b1;
          end else if (drop_q) begin
            pc_d = tgt_q;
          end else begin
            load_s = 1'b1;
            pc_d   = pc_q + 32'd4;
          end
        end else begin
          wait_cnt_d = cnt_inc_s;
          if (redirect) begin
            drop_d  = 1'b1;
            tgt_d   = redir_pc_s;
            flush_s = 1'b1;
          end else begin
            drop_d = drop_q;
          end
        end
      end
      ERR: begin
        fetch_err_d = 1'b1;
      end
      default: begin
        pc_d = pc_q;
      end
    endcase

`ifdef FETCH_SKID_EN
    if (flush_s) begin
      inst_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop_s && skid_valid_q) begin
      inst_valid_d = 1'b1;
      inst_out_d   = skid_out_q;
      inst_pc_d    = skid_pc_q;
      skid_valid_d = load_s;
      if (load_s) begin
        skid_out_d = im_rdata;
        skid_pc_d  = pc_q;
      end else begin
        skid_out_d = skid_out_q;
      end
    end else if (pop_s || !inst_valid_q) begin
      inst_valid_d = load_s;
      if (load_s) begin
        inst_out_d = im_rdata;
        inst_pc_d  = pc_q;
      end else begin
        inst_out_d = inst_out_q;
      end
    end else begin
      skid_valid_d = skid_valid_q | load_s;
      if (load_s) begin
        skid_out_d = im_rdata;
        skid_pc_d  = pc_q;
      end else begin
        skid_out_d = skid_out_q;
      end
    end
    free_s = ~(inst_valid_d & skid_valid_d);
`else
    if (flush_s) begin
      inst_valid_d = 1'b0;
    end else if (load_s) begin
      inst_valid_d = 1'b1;
      inst_out_d   = im_rdata;
      inst_pc_d    = pc_q;
    end else if (pop_s) begin
      inst_valid_d = 1'b0;
    end else begin
      inst_valid_d = inst_valid_q;
    end
    free_s = ~inst_valid_d;
`endif

    case (state_q)
      IDLE, WAIT: begin
        if (!halt && free_s) begin
          state_d = REQ;
        end else begin
          state_d = state_q;
        end
      end
      REQ: begin
        if (im_ack) begin
          if (!free_s) begin
            state_d = WAIT;
          end else if (halt) begin
            state_d = IDLE;
          end else begin
            state_d = REQ;
          end
        end else if (cnt_inc_s == TIMEOUT_C) begin
          state_d     = ERR;
          fetch_err_d = 1'b1;
        end else begin
          state_d = REQ;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    im_req_d = (state_d == REQ);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC_C;
      tgt_q        <= 32'd0;
      drop_q       <= 1'b0;
      wait_cnt_q   <= 8'd0;
      im_req_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= 32'd0;
      inst_pc_q    <= 32'd0;
      fetch_err_q  <= 1'b0;
`ifdef FETCH_SKID_EN
      skid_valid_q <= 1'b0;
      skid_out_q   <= 32'd0;
      skid_pc_q    <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      drop_q       <= drop_d;
      wait_cnt_q   <= wait_cnt_d;
      im_req_q     <= im_req_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      fetch_err_q  <= fetch_err_d;
`ifdef FETCH_SKID_EN
      skid_valid_q <= skid_valid_d;
      skid_out_q   <= skid_out_d;
      skid_pc_q    <= skid_pc_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (default build, single-entry buffer).
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fetch_err;

  int checks_n = 0;
  int fail_n   = 0;
  int req_cycles;

  fetch_sequencer #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_ack     (im_ack),
    .im_rdata   (im_rdata),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .id_ready   (id_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_n++;
    if (obs !== exp) begin
      fail_n++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    im_ack      = 1'b0;
    im_rdata    = 32'd0;
    id_ready    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    halt        = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_req",   im_req,     32'd0);
    check_eq("rst_addr",  im_addr,    32'd0);
    check_eq("rst_valid", inst_valid, 32'd0);
    check_eq("rst_out",   inst_out,   32'd0);
    check_eq("rst_pc",    inst_pc,    32'd0);
    check_eq("rst_err",   fetch_err,  32'd0);
    reset = 1'b1;

    // zero-wait IM, id_ready=1: one instruction every two cycles
    @(negedge clk);
    check_eq("t1_req0", im_req, 32'd1);
    check_eq("t1_addr0", im_addr, 32'h0000_0000);
    im_ack = 1'b1; im_rdata = 32'h1111_0000;
    @(negedge clk);
    check_eq("t1_valid0", inst_valid, 32'd1);
    check_eq("t1_out0", inst_out, 32'h1111_0000);
    check_eq("t1_pc0", inst_pc, 32'h0000_0000);
    check_eq("t1_noreq", im_req, 32'd0);
    im_ack = 1'b0;
    @(negedge clk);
    check_eq("t1_req4", im_req, 32'd1);
    check_eq("t1_addr4", im_addr, 32'h0000_0004);
    check_eq("t1_gap", inst_valid, 32'd0);
    im_ack = 1'b1; im_rdata = 32'h1111_0004;
    @(negedge clk);
    check_eq("t1_valid4", inst_valid, 32'd1);
    check_eq("t1_pc4", inst_pc, 32'h0000_0004);
    check_eq("t1_out4", inst_out, 32'h1111_0004);
    im_ack = 1'b0;
    @(negedge clk);
    check_eq("t1_addr8", im_addr, 32'h0000_0008);
    im_ack = 1'b1; im_rdata = 32'h1111_0008;
    @(negedge clk);
    check_eq("t1_pc8", inst_pc, 32'h0000_0008);
    check_eq("t1_valid8", inst_valid, 32'd1);
    im_ack = 1'b0;

    // ack delayed 3 cycles: address stable for 4 request cycles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t2_req", im_req, 32'd1);
      check_eq("t2_addr", im_addr, 32'h0000_000C);
      check_eq("t2_novalid", inst_valid, 32'd0);
    end
    im_ack = 1'b1; im_rdata = 32'hC000_0010;
    @(negedge clk);
    check_eq("t2_valid", inst_valid, 32'd1);
    check_eq("t2_out", inst_out, 32'hC000_0010);
    check_eq("t2_pc", inst_pc, 32'h0000_000C);
    im_ack = 1'b0;
    id_ready = 1'b0;

    // ID stalls 5 cycles: buffer holds, no new request
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t3_valid", inst_valid, 32'd1);
      check_eq("t3_out", inst_out, 32'hC000_0010);
      check_eq("t3_pc", inst_pc, 32'h0000_000C);
      check_eq("t3_noreq", im_req, 32'd0);
    end
    id_ready = 1'b1;
    @(negedge clk);
    check_eq("t3_req", im_req, 32'd1);
    check_eq("t3_addr", im_addr, 32'h0000_0010);
    check_eq("t3_drained", inst_valid, 32'd0);

    // redirect against an outstanding request, ack two cycles later
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect = 1'b0;
    check_eq("t4_req_hold", im_req, 32'd1);
    check_eq("t4_addr_hold", im_addr, 32'h0000_0010);
    check_eq("t4_novalid", inst_valid, 32'd0);
    @(negedge clk);
    check_eq("t4_addr_hold2", im_addr, 32'h0000_0010);
    im_ack = 1'b1; im_rdata = 32'hDEAD_0010;
    @(negedge clk);
    check_eq("t4_dropped", inst_valid, 32'd0);
    check_eq("t4_req_new", im_req, 32'd1);
    check_eq("t4_addr_new", im_addr, 32'h0000_0100);
    im_ack = 1'b1; im_rdata = 32'h5100_0100;
    @(negedge clk);
    check_eq("t4_valid", inst_valid, 32'd1);
    check_eq("t4_pc", inst_pc, 32'h0000_0100);
    check_eq("t4_out", inst_out, 32'h5100_0100);
    im_ack = 1'b0;

    // redirect coincident with ack: word discarded, next request to target
    @(negedge clk);
    check_eq("t5_addr", im_addr, 32'h0000_0104);
    check_eq("t5_req", im_req, 32'd1);
    im_ack = 1'b1; im_rdata = 32'hBAD0_0104;
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk);
    im_ack = 1'b0; redirect = 1'b0;
    check_eq("t5_discard", inst_valid, 32'd0);
    check_eq("t5_req_tgt", im_req, 32'd1);
    check_eq("t5_addr_tgt", im_addr, 32'h0000_0200);

    // ack never arrives: error after TIMEOUT request cycles
    req_cycles = 0;
    for (int i = 0; i < 40 && im_req === 1'b1; i++) begin
      req_cycles++;
      @(negedge clk);
    end
    check_eq("t6_req_cycles", req_cycles, 32'd16);
    check_eq("t6_err", fetch_err, 32'd1);
    check_eq("t6_req_off", im_req, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    @(negedge clk);
    redirect = 1'b0;
    check_eq("t6_err_sticky", fetch_err, 32'd1);
    check_eq("t6_err_noreq", im_req, 32'd0);
    check_eq("t6_err_noredir", im_addr, 32'h0000_0200);
    reset = 1'b0; halt = 1'b1;
    #1;
    check_eq("t6_rst_err", fetch_err, 32'd0);
    check_eq("t6_rst_addr", im_addr, 32'h0000_0000);

    // halt: no request; redirect during halt moves pc only
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("h_noreq", im_req, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0042;
    @(negedge clk);
    redirect = 1'b0;
    check_eq("h_noreq2", im_req, 32'd0);
    check_eq("h_addr", im_addr, 32'h0000_0040);
    halt = 1'b0;
    @(negedge clk);
    check_eq("h_req", im_req, 32'd1);
    check_eq("h_req_addr", im_addr, 32'h0000_0040);

    // reset mid-request: im_req drops at once, late ack ignored
    #2;
    reset = 1'b0;
    #1;
    check_eq("r_req_drop", im_req, 32'd0);
    check_eq("r_addr", im_addr, 32'h0000_0000);
    @(negedge clk);
    reset = 1'b1; im_ack = 1'b1; im_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    im_ack = 1'b0;
    check_eq("r_late_ack", inst_valid, 32'd0);
    check_eq("r_req", im_req, 32'd1);
    check_eq("r_req_addr", im_addr, 32'h0000_0000);
    @(negedge clk);
    check_eq("r_still_empty", inst_valid, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
    $finish;
  end

endmodule
